// File: rtl/phase_sequencer.sv
// Frame-level phase controller: steps INP -> ACT -> DISP with one-cycle gaps and counts completed frames.
// Optional per-phase watchdog is built when PHASE_WATCHDOG_EN is defined.
module phase_sequencer #(
   parameter int TO_W    = 8,
   parameter int TIMEOUT = 200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run_i,
   input  logic       d_inp_i,
   input  logic       d_act_i,
   input  logic       d_disp_i,
   output logic       e_inp_o,
   output logic       e_act_o,
   output logic       e_disp_o,
   output logic [2:0] phase_o,
   output logic       busy_o,
   output logic [7:0] frame_cnt_o,
   output logic       timeout_o
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_INP  = 3'd1,
      S_GAP1 = 3'd2,
      S_ACT  = 3'd3,
      S_GAP2 = 3'd4,
      S_DISP = 3'd5
   } state_t;

   state_t state, state_nxt;
   logic   frame_done;
   logic   wd_expire;

   // Handshake: a phase's enable is a level held until the cycle its done flag is
   // sampled high; done is only looked at while that same enable is high, so done
   // flags from other blocks or outside a phase have no effect.
   always_comb begin
      state_nxt  = state;
      frame_done = 1'b0;
      case (state)
         S_IDLE: if (run_i) state_nxt = S_INP;
         S_INP:  if (d_inp_i || wd_expire) state_nxt = S_GAP1;
         S_GAP1: state_nxt = S_ACT;
         S_ACT:  if (d_act_i || wd_expire) state_nxt = S_GAP2;
         S_GAP2: state_nxt = S_DISP;
         S_DISP: begin
            if (d_disp_i || wd_expire) begin
               state_nxt  = S_IDLE;
               frame_done = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Enables are decoded from the next state so they are clean flops aligned with state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         e_inp_o     <= 1'b0;
         e_act_o     <= 1'b0;
         e_disp_o    <= 1'b0;
         frame_cnt_o <= 8'd0;
      end else begin
         state    <= state_nxt;
         e_inp_o  <= (state_nxt == S_INP);
         e_act_o  <= (state_nxt == S_ACT);
         e_disp_o <= (state_nxt == S_DISP);
         if (frame_done) frame_cnt_o <= frame_cnt_o + 8'd1;
      end
   end

   assign phase_o = state;
   assign busy_o  = (state != S_IDLE);

`ifdef PHASE_WATCHDOG_EN
   logic [TO_W-1:0] wd_cnt;
   logic            wd_phase;
   logic            own_done;
   logic            timeout_r;

   assign wd_phase  = (state == S_INP) || (state == S_ACT) || (state == S_DISP);
   assign own_done  = ((state == S_INP) && d_inp_i) || ((state == S_ACT) && d_act_i) ||
                      ((state == S_DISP) && d_disp_i);
   assign wd_expire = wd_phase && (wd_cnt == TO_W'(TIMEOUT - 1));

   // A done arriving in the expiry cycle is a normal advance and leaves the flag clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt    <= '0;
         timeout_r <= 1'b0;
      end else begin
         if (state_nxt != state) wd_cnt <= '0;
         else if (wd_phase)      wd_cnt <= wd_cnt + 1'b1;
         if (wd_expire && !own_done) timeout_r <= 1'b1;
      end
   end

   assign timeout_o = timeout_r;
`else
   logic unused_cfg;

   assign wd_expire  = 1'b0;
   assign timeout_o  = 1'b0;
   assign unused_cfg = ^{TO_W, TIMEOUT};
`endif

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Frame-level controller for the drops game datapath: sequences the input-sampling, game-action and display-refresh phases by issuing one level enable at a time and waiting for each block's done flag. It sits at the top level between the pin-level clock/reset and the three datapath blocks. It replaces ad-hoc phase logic with a single rising-edge FSM that adds:
- run/pause control
- a completed-frame counter
- an optional per-phase watchdog

## Interface
Parameters:
- `TO_W`, default 8: watchdog counter width. `TIMEOUT` ≤ 2^`TO_W` is required.
- `TIMEOUT`, default 200: maximum number of cycles a phase may stay enabled before a forced advance.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `run_i`  in  1  1 = start and continue frames; 0 = stop at the next frame boundary.
- `d_inp_i`  in  1  done from the input block.
- `d_act_i`  in  1  done from the action block.
- `d_disp_i`  in  1  done from the display block.
- `e_inp_o`  out  1  input-phase enable (level).
- `e_act_o`  out  1  action-phase enable (level).
- `e_disp_o`  out  1  display-phase enable (level).
- `phase_o`  out  3  current FSM state encoding.
- `busy_o`  out  1  high whenever state ≠ IDLE.
- `frame_cnt_o`  out  8  count of completed frames; wraps.
- `timeout_o`  out  1  sticky watchdog flag.

## Operation
- States and encodings: IDLE=0, INP=1, GAP1=2, ACT=3, GAP2=4, DISP=5. Codes 6 and 7 are illegal and go to IDLE on the next cycle.
- Transitions:
  - IDLE→INP when `run_i`=1.
  - INP→GAP1 on `d_inp_i`=1.
  - GAP1→ACT unconditionally.
  - ACT→GAP2 on `d_act_i`=1.
  - GAP2→DISP unconditionally.
  - DISP→IDLE on `d_disp_i`=1.
- Enables are Moore outputs, registered: `e_inp_o`=(state==INP), `e_act_o`=(state==ACT), `e_disp_o`=(state==DISP). At most one enable is high in any cycle.
- Each enable drops for at least one cycle between phases: the GAP states provide this for INP→ACT and ACT→DISP, and IDLE provides it for DISP→INP.
- A done flag is honoured only while its own enable is high. Done flags for other phases are ignored. Done flags arriving in IDLE or GAP states are ignored.
- Simultaneous done flags: only the flag belonging to the current phase has effect.
- `frame_cnt_o` increments by 1 on every DISP→IDLE transition, modulo 256 (255→0).
- `run_i` deasserted mid-frame: the current frame runs to completion and the FSM parks in IDLE. `run_i` is only sampled in IDLE.
- Reset at any time: state=IDLE, all enables 0, `busy_o`=0, `frame_cnt_o`=0, `timeout_o`=0, watchdog count=0. This takes effect immediately, asynchronously, including mid-phase.

## Timing
- IDLE with `run_i`=1 at edge n → `e_inp_o`=1 after edge n.
- A done flag sampled high at edge m → the enable is low after edge m. The next phase's enable is high after edge m+1.
- Minimum frame with all done flags returned in the first enabled cycle: 6 cycles (IDLE, INP, GAP1, ACT, GAP2, DISP).
- `frame_cnt_o` and `busy_o`=0 update on the same edge as DISP→IDLE.
- `phase_o` always equals the registered state, with no extra latency.

## Configuration
- Macro `PHASE_WATCHDOG_EN`, defined:
  - A `TO_W`-bit counter clears on entry to INP, ACT or DISP and increments each cycle the FSM stays in that state.
  - If the count reaches `TIMEOUT`-1 and the phase's done flag is still low, the FSM advances exactly as if done had been asserted.
  - That forced advance sets `timeout_o`=1. The flag stays set until reset.
  - A done flag and expiry in the same cycle count as a normal advance; `timeout_o` is not set.
- Macro not defined: no counter is built, phases wait indefinitely for their done flag, and `timeout_o` is tied to 0.

## Test plan
- Reset then `run_i`=1, each done flag returned 1 cycle after its enable rises → enable sequence INP,ACT,DISP with one-cycle gaps; frame length 9 cycles; `frame_cnt_o`=1 after the first frame.
- `d_act_i` and `d_disp_i` held high during INP → stays in INP until `d_inp_i`=1; `e_act_o`/`e_disp_o` never high early.
- `run_i` dropped during ACT → frame completes, `frame_cnt_o` increments once, FSM parks in IDLE with `busy_o`=0 and all enables 0.
- `rst_n` pulsed low mid-DISP, between edges → all outputs 0 immediately, before the next rising edge; restart begins at INP.
- 256 back-to-back frames → `frame_cnt_o` wraps 255→0.
- `PHASE_WATCHDOG_EN` defined, `TIMEOUT`=10, `d_act_i` never asserted → `e_act_o` high for exactly 10 cycles, then GAP2, `timeout_o`=1 and sticky until reset.
